// File: rtl/regfile_writeback_unit_pkg.sv
// Shared register-file types for the writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int NUM_REGS  = 8;
    localparam int DATA_W    = 8;
    localparam int REG_IDX_W = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;

    typedef struct packed {
        reg_idx_t rd;
        data_t    data;
    } wb_req_t;

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Bundles the ALU, load-return, hazard and register-file write signals.
// Latency: n/a (wiring only).
// Backpressure: aluReady and loadQueueFull flow back to the producers.
interface regfile_writeback_unit_if import cpu_pkg::*; ;

    logic     aluValid;
    reg_idx_t aluReg;
    data_t    aluData;
    logic     aluReady;
    logic     loadIssue;
    reg_idx_t loadIssueReg;
    logic     loadValid;
    data_t    loadData;
    logic     loadQueueFull;
    reg_idx_t readRegister1;
    reg_idx_t readRegister2;
    logic     stall;
    logic     regWrite;
    reg_idx_t writeRegister;
    data_t    writeData;
    logic     errorFlag;

    // Producer/decode/register-file side
    modport master (
        output aluValid, aluReg, aluData, loadIssue, loadIssueReg,
               loadValid, loadData, readRegister1, readRegister2,
        input  aluReady, loadQueueFull, stall, regWrite, writeRegister,
               writeData, errorFlag
    );

    // Writeback unit side
    modport slave (
        input  aluValid, aluReg, aluData, loadIssue, loadIssueReg,
               loadValid, loadData, readRegister1, readRegister2,
        output aluReady, loadQueueFull, stall, regWrite, writeRegister,
               writeData, errorFlag
    );

endinterface

// File: rtl/regfile_writeback_unit_load_tag_fifo.sv
// Circular queue of destination tags for loads in flight, in issue order.
// Latency: push/pop take effect on the next edge; head is combinational.
// Backpressure: caller must not push when full unless popping the same cycle.
module load_tag_fifo import cpu_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  reg_idx_t            pushData,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output reg_idx_t            head,
    output logic [NUM_REGS-1:0] match
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    reg_idx_t          mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  offset;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rdPtr];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registers still targeted by a queued tag once this cycle's pop is gone.
    always_comb begin
        match  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rdPtr;
            if ((CNT_W'(offset) < count) && !(pop && (offset == '0)))
                match[mem[i]] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Sole driver of the register-file write port: merges ALU and load results.
// Latency: 1 cycle from accepted valid to regWrite; a load losing to the ALU waits in lbuf.
// Backpressure: aluReady drops while lbuf is held; stall raised on read-after-load hazards.
module regfile_writeback_unit import cpu_pkg::*; #(
    parameter int LOAD_DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    regfile_writeback_unit_if.slave   bus
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_n;
    logic                lbufValid;
    logic                lbufValid_n;
    wb_req_t             lbuf;
    wb_req_t             lbuf_n;

    logic                qFull;
    logic                qEmpty;
    reg_idx_t            qHead;
    logic [NUM_REGS-1:0] qMatch;
    logic                qPush;
    logic                qPop;

    logic                aluErr;
    logic                issueErr;
    logic                loadErr;
    logic                aluAccept;
    logic                loadAccept;

    logic                winVld;
    logic                winIsLoad;
    wb_req_t             win;

    logic                regWrite;
    reg_idx_t            writeRegister;
    data_t               writeData;
    logic                errorFlag;

    load_tag_fifo #(.DEPTH(LOAD_DEPTH)) u_tags (
        .clock    (clock),
        .reset    (reset),
        .push     (qPush),
        .pushData (bus.loadIssueReg),
        .pop      (qPop),
        .full     (qFull),
        .empty    (qEmpty),
        .head     (qHead),
        .match    (qMatch)
    );

    assign bus.aluReady      = !lbufValid;
    assign bus.loadQueueFull = qFull;
    assign bus.stall         = pending[bus.readRegister1] | pending[bus.readRegister2] | lbufValid;
    assign bus.regWrite      = regWrite;
    assign bus.writeRegister = writeRegister;
    assign bus.writeData     = writeData;
    assign bus.errorFlag     = errorFlag;

    // Protocol checks: offending ALU writes, issues and empty-queue returns are dropped.
    always_comb begin
        loadAccept = bus.loadValid && !qEmpty;
        loadErr    = bus.loadValid && qEmpty;
        qPop       = loadAccept;
        issueErr   = bus.loadIssue && qFull && !qPop;
        qPush      = bus.loadIssue && !issueErr;
        aluErr     = bus.aluValid && (lbufValid || pending[bus.aluReg]);
        aluAccept  = bus.aluValid && !aluErr;
    end

    // One winner per cycle: held load, then ALU, then a direct load return.
    always_comb begin
        winVld      = 1'b0;
        winIsLoad   = 1'b0;
        win         = '0;
        lbufValid_n = lbufValid;
        lbuf_n      = lbuf;
        if (lbufValid) begin
            winVld      = 1'b1;
            winIsLoad   = 1'b1;
            win         = lbuf;
            lbufValid_n = loadAccept;
            if (loadAccept) lbuf_n = '{rd: qHead, data: bus.loadData};
        end else if (aluAccept) begin
            winVld = 1'b1;
            win    = '{rd: bus.aluReg, data: bus.aluData};
            if (loadAccept) begin
                lbufValid_n = 1'b1;
                lbuf_n      = '{rd: qHead, data: bus.loadData};
            end
        end else if (loadAccept) begin
            winVld    = 1'b1;
            winIsLoad = 1'b1;
            win       = '{rd: qHead, data: bus.loadData};
        end
    end

    // A register stays pending while any load to it is queued, buffered or being written.
    always_comb begin
        pending_n = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_n[r] = (qPush && (bus.loadIssueReg == reg_idx_t'(r)))
                         | (pending[r] & ( qMatch[r]
                                         | (lbufValid_n && (lbuf_n.rd == reg_idx_t'(r)))
                                         | (winVld && winIsLoad && (win.rd == reg_idx_t'(r)))));
        end
    end

    // Write-port registers, load buffer, pending bits and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            errorFlag     <= 1'b0;
            lbufValid     <= 1'b0;
            lbuf          <= '0;
            pending       <= '0;
        end else begin
            regWrite <= winVld;
            if (winVld) begin
                writeRegister <= win.rd;
                writeData     <= win.data;
            end
            errorFlag <= errorFlag | aluErr | issueErr | loadErr;
            lbufValid <= lbufValid_n;
            lbuf      <= lbuf_n;
            pending   <= pending_n;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for the register-file writeback unit.
// Latency: checks 1-cycle write latency and buffered-load ordering.
// Backpressure: exercises aluReady, loadQueueFull and stall.
module tb_regfile_writeback_unit;
    import cpu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    regfile_writeback_unit_if bus ();

    regfile_writeback_unit #(.LOAD_DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.aluValid      = 1'b0;
        bus.aluReg        = '0;
        bus.aluData       = '0;
        bus.loadIssue     = 1'b0;
        bus.loadIssueReg  = '0;
        bus.loadValid     = 1'b0;
        bus.loadData      = '0;
        bus.readRegister1 = '0;
        bus.readRegister2 = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input reg_idx_t r);
        bus.loadIssue = 1'b1; bus.loadIssueReg = r;
        tick();
        bus.loadIssue = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%b reg=%0d data=%h err=%b want all 0",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag);
        end
        checks++;
        if ({bus.stall, bus.aluReady, bus.loadQueueFull} !== 3'b010) begin
            fails++;
            $display("FAIL reset_status: got stall/rdy/full=%b%b%b want 010",
                     bus.stall, bus.aluReady, bus.loadQueueFull);
        end
    endtask

    task automatic test_alu_write();
        bus.aluValid = 1'b1; bus.aluReg = 3'd3; bus.aluData = 8'h5A;
        tick();
        idle();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData} !== {1'b1, 3'd3, 8'h5A}) begin
            fails++;
            $display("FAIL alu_write: got %b/%0d/%h want 1/3/5a", bus.regWrite, bus.writeRegister, bus.writeData);
        end
        tick();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag} !== {1'b0, 3'd3, 8'h5A, 1'b0}) begin
            fails++;
            $display("FAIL alu_idle_hold: got we=%b %0d/%h err=%b want 0 3/5a err 0",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag);
        end
    endtask

    task automatic test_load_hazard();
        bus.readRegister1 = 3'd2;
        issue(3'd2);
        checks++;
        if (bus.stall !== 1'b1) begin fails++; $display("FAIL load_stall_set: got %b want 1", bus.stall); end
        tick();
        bus.loadValid = 1'b1; bus.loadData = 8'hC3;
        tick();
        bus.loadValid = 1'b0;
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.stall} !== {1'b1, 3'd2, 8'hC3, 1'b1}) begin
            fails++;
            $display("FAIL load_write: got %b/%0d/%h stall=%b want 1/2/c3 stall 1",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.stall);
        end
        tick();
        checks++;
        if ({bus.regWrite, bus.stall} !== 2'b00) begin
            fails++;
            $display("FAIL load_stall_clear: got we=%b stall=%b want 0 0", bus.regWrite, bus.stall);
        end
    endtask

    task automatic test_alu_load_collision();
        issue(3'd4);
        bus.aluValid = 1'b1; bus.aluReg = 3'd1; bus.aluData = 8'h11;
        bus.loadValid = 1'b1; bus.loadData = 8'h44;
        tick();
        idle();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.aluReady, bus.stall} !== {1'b1, 3'd1, 8'h11, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL collide_alu_first: got %b/%0d/%h rdy=%b stall=%b want 1/1/11 rdy 0 stall 1",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.aluReady, bus.stall);
        end
        tick();
        bus.readRegister1 = 3'd4;
        #1;
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.aluReady, bus.stall} !== {1'b1, 3'd4, 8'h44, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL collide_load_second: got %b/%0d/%h rdy=%b stall=%b want 1/4/44 rdy 1 stall 1",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.aluReady, bus.stall);
        end
        tick();
        checks++;
        if (bus.stall !== 1'b0) begin fails++; $display("FAIL collide_stall_clear: got %b want 0", bus.stall); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        issue(3'd5);
        issue(3'd6);
        bus.loadIssue = 1'b1; bus.loadIssueReg = 3'd3;
        bus.loadValid = 1'b1; bus.loadData = 8'hAA;
        tick();
        idle();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag, bus.loadQueueFull} !== {1'b1, 3'd5, 8'hAA, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL full_push_pop: got %b/%0d/%h err=%b full=%b want 1/5/aa err 0 full 1",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag, bus.loadQueueFull);
        end
        bus.loadValid = 1'b1; bus.loadData = 8'hBB;
        tick();
        bus.loadData = 8'hCC;
        tick();
        idle();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.loadQueueFull} !== {1'b1, 3'd3, 8'hCC, 1'b0}) begin
            fails++;
            $display("FAIL full_push_pop_order: got %b/%0d/%h full=%b want 1/3/cc full 0",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.loadQueueFull);
        end
    endtask

    task automatic test_queue_overflow();
        do_reset();
        issue(3'd5);
        issue(3'd6);
        checks++;
        if ({bus.loadQueueFull, bus.errorFlag} !== 2'b10) begin
            fails++;
            $display("FAIL queue_full: got full=%b err=%b want 1 0", bus.loadQueueFull, bus.errorFlag);
        end
        issue(3'd0);
        checks++;
        if ({bus.errorFlag, bus.loadQueueFull, bus.stall} !== 3'b110) begin
            fails++;
            $display("FAIL overflow_err: got err=%b full=%b stall(r0)=%b want 1 1 0",
                     bus.errorFlag, bus.loadQueueFull, bus.stall);
        end
        bus.loadValid = 1'b1; bus.loadData = 8'hAA;
        tick();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData} !== {1'b1, 3'd5, 8'hAA}) begin
            fails++;
            $display("FAIL overflow_ret1: got %b/%0d/%h want 1/5/aa", bus.regWrite, bus.writeRegister, bus.writeData);
        end
        bus.loadData = 8'hBB;
        tick();
        idle();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.loadQueueFull} !== {1'b1, 3'd6, 8'hBB, 1'b0}) begin
            fails++;
            $display("FAIL overflow_ret2: got %b/%0d/%h full=%b want 1/6/bb full 0",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.loadQueueFull);
        end
    endtask

    task automatic test_double_load_same_reg();
        do_reset();
        bus.readRegister2 = 3'd7;
        issue(3'd7);
        issue(3'd7);
        bus.aluValid = 1'b1; bus.aluReg = 3'd7; bus.aluData = 8'h99;
        tick();
        bus.aluValid = 1'b0;
        checks++;
        if ({bus.regWrite, bus.errorFlag} !== 2'b01) begin
            fails++;
            $display("FAIL waw_drop: got we=%b err=%b want 0 1", bus.regWrite, bus.errorFlag);
        end
        bus.loadValid = 1'b1; bus.loadData = 8'h01;
        tick();
        bus.loadValid = 1'b0;
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData} !== {1'b1, 3'd7, 8'h01}) begin
            fails++;
            $display("FAIL r7_first: got %b/%0d/%h want 1/7/01", bus.regWrite, bus.writeRegister, bus.writeData);
        end
        tick();
        checks++;
        if (bus.stall !== 1'b1) begin fails++; $display("FAIL r7_still_pending: got stall=%b want 1", bus.stall); end
        bus.loadValid = 1'b1; bus.loadData = 8'h02;
        tick();
        bus.loadValid = 1'b0;
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.stall} !== {1'b1, 3'd7, 8'h02, 1'b1}) begin
            fails++;
            $display("FAIL r7_second: got %b/%0d/%h stall=%b want 1/7/02 stall 1",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.stall);
        end
        tick();
        checks++;
        if (bus.stall !== 1'b0) begin fails++; $display("FAIL r7_stall_clear: got %b want 0", bus.stall); end
    endtask

    task automatic test_alu_not_ready();
        do_reset();
        issue(3'd4);
        bus.aluValid = 1'b1; bus.aluReg = 3'd1; bus.aluData = 8'h11;
        bus.loadValid = 1'b1; bus.loadData = 8'h44;
        tick();
        bus.loadValid = 1'b0;
        bus.aluReg = 3'd2; bus.aluData = 8'h77;
        tick();
        idle();
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag} !== {1'b1, 3'd4, 8'h44, 1'b1}) begin
            fails++;
            $display("FAIL alu_not_ready: got %b/%0d/%h err=%b want 1/4/44 err 1",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag);
        end
        tick();
        checks++;
        if (bus.regWrite !== 1'b0) begin fails++; $display("FAIL alu_dropped: got we=%b want 0", bus.regWrite); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        issue(3'd3);
        issue(3'd4);
        bus.aluValid = 1'b1; bus.aluReg = 3'd1; bus.aluData = 8'h11;
        bus.loadValid = 1'b1; bus.loadData = 8'h55;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.readRegister1 = 3'd4; bus.readRegister2 = 3'd3;
        #1;
        checks++;
        if ({bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag, bus.stall, bus.aluReady, bus.loadQueueFull}
                !== {1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset: got %b/%0d/%h err=%b stall=%b rdy=%b full=%b want 0/0/00 err 0 stall 0 rdy 1 full 0",
                     bus.regWrite, bus.writeRegister, bus.writeData, bus.errorFlag, bus.stall, bus.aluReady, bus.loadQueueFull);
        end
        bus.loadValid = 1'b1; bus.loadData = 8'h66;
        tick();
        idle();
        checks++;
        if ({bus.regWrite, bus.errorFlag} !== 2'b01) begin
            fails++;
            $display("FAIL stray_load: got we=%b err=%b want 0 1", bus.regWrite, bus.errorFlag);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_write();
        test_load_hazard();
        test_alu_load_collision();
        test_full_push_pop();
        test_queue_overflow();
        test_double_load_same_reg();
        test_alu_not_ready();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
